// File: rtl/uarttx_arb_pkg.sv
// Shared state encoding and constants for the two-source UART transmit arbiter.
// Defining UARTTX_ARB_HDR_EN adds the per-frame header state HDR.
package uarttx_arb_pkg;

  localparam int         FRAME_BYTES_DEFAULT = 892;
  localparam int         CNT_W_DEFAULT       = 10;
  localparam logic [7:0] HDR_BASE            = 8'hA0;
  localparam logic       SRC0                = 1'b0;
  localparam logic       SRC1                = 1'b1;

`ifdef UARTTX_ARB_HDR_EN
  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    WAIT_DONE,
    WAIT_DATA,
    HDR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    WAIT_DONE,
    WAIT_DATA
  } state_t;
`endif

  // Source index of a one-hot grant; 2'b00 maps to source 0.
  function automatic logic src_index(input logic [1:0] onehot);
    return onehot[1] ? SRC1 : SRC0;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [1:0] onehot);
    return HDR_BASE | {7'd0, src_index(onehot)};
  endfunction

endpackage

// File: rtl/uarttx_fifo_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the priority pointer moves past the source
// just served each time a frame completes.
module rr_arb2
  import uarttx_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic [1:0] sel
);

  logic ptr;

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= SRC0;
    end else if (update) begin
      ptr <= ~served;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    sel = 2'b00;
    case (req)
      2'b01:   sel = 2'b01;
      2'b10:   sel = 2'b10;
      2'b11:   sel = (ptr == SRC0) ? 2'b01 : 2'b10;
      default: sel = 2'b00;
    endcase
  end

endmodule

// File: rtl/uarttx_fifo_arbiter.sv
// Drains one of two byte FIFOs into a UART transmitter in fixed-length frames.
// Defining UARTTX_ARB_HDR_EN prefixes each frame with header byte 8'hA0 | source.
module uarttx_fifo_arbiter
  import uarttx_arb_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic       out_clk,
  input  logic       rst,
  input  logic       transmit_en,
  input  logic       fifo0_empty,
  input  logic       fifo1_empty,
  input  logic [7:0] fifo0_dout,
  input  logic [7:0] fifo1_dout,
  output logic       fifo0_rden,
  output logic       fifo1_rden,
  output logic [7:0] tx_byte,
  output logic       tx_dv,
  input  logic       tx_done,
  output logic [1:0] grant,
  output logic       frame_done
);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       req;
  logic [1:0]       sel;
  logic             grant_empty;
  logic             last_byte;
  logic [7:0]       byte_in;
  logic             start;
  logic             rd;
  logic             load_byte;
  logic             byte_done;
  logic             frame_end;

  // transmit_en only matters for starting a frame; an open frame always finishes.
  assign req         = {~fifo1_empty, ~fifo0_empty} & {2{transmit_en}};
  assign grant_empty = |(grant & {fifo1_empty, fifo0_empty});
  assign last_byte   = (cnt == CNT_W'(FRAME_BYTES - 1));
  assign byte_in     = grant[1] ? fifo1_dout : fifo0_dout;

  rr_arb2 u_arb (
    .clk    (out_clk),
    .rst    (rst),
    .req    (req),
    .update (frame_end),
    .served (src_index(grant)),
    .sel    (sel)
  );

  always_ff @(posedge out_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    start     = 1'b0;
    rd        = 1'b0;
    load_byte = 1'b0;
    byte_done = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (|sel) begin
          start = 1'b1;
`ifdef UARTTX_ARB_HDR_EN
          state_d = HDR;
`else
          state_d = READ;
`endif
        end
      end
`ifdef UARTTX_ARB_HDR_EN
      HDR: begin
        if (tx_done) begin
          state_d = grant_empty ? WAIT_DATA : READ;
        end
      end
`endif
      READ: begin
        // The empty gate is a guard; READ is only entered with data present.
        rd      = ~grant_empty;
        state_d = grant_empty ? WAIT_DATA : LOAD;
      end
      LOAD: begin
        load_byte = 1'b1;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (last_byte) begin
            frame_end = 1'b1;
            state_d   = IDLE;
          end else begin
            byte_done = 1'b1;
            state_d   = grant_empty ? WAIT_DATA : READ;
          end
        end
      end
      WAIT_DATA: begin
        if (!grant_empty) begin
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo0_rden = rd & grant[0];
  assign fifo1_rden = rd & grant[1];

  always_ff @(posedge out_clk or posedge rst) begin
    if (rst) begin
      grant      <= 2'b00;
      cnt        <= '0;
      tx_byte    <= 8'h00;
      tx_dv      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_dv      <= 1'b0;
      frame_done <= frame_end;
      if (start) begin
        grant <= sel;
`ifdef UARTTX_ARB_HDR_EN
        tx_byte <= hdr_byte(sel);
        tx_dv   <= 1'b1;
`endif
      end
      if (frame_end) begin
        grant <= 2'b00;
        cnt   <= '0;
      end
      if (byte_done) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (load_byte) begin
        tx_byte <= byte_in;
        tx_dv   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uarttx_fifo_arbiter.sv
// Scoreboard bench for uarttx_fifo_arbiter: FIFO and UART models, expected bytes
// queued at stimulus time and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_uarttx_fifo_arbiter;
  import uarttx_arb_pkg::*;

  localparam int FB       = 892;
  localparam int UART_LAT = 2;
`ifdef UARTTX_ARB_HDR_EN
  localparam int HDR_N = 1;
`else
  localparam int HDR_N = 0;
`endif
  localparam int FRAME_BUDGET = 7 * (FB + 2) + 200;

  logic       out_clk     = 1'b0;
  logic       rst         = 1'b1;
  logic       transmit_en = 1'b0;
  logic       fifo0_empty = 1'b1;
  logic       fifo1_empty = 1'b1;
  logic [7:0] fifo0_dout  = 8'h00;
  logic [7:0] fifo1_dout  = 8'h00;
  logic       fifo0_rden;
  logic       fifo1_rden;
  logic [7:0] tx_byte;
  logic       tx_dv;
  logic       tx_done     = 1'b0;
  logic [1:0] grant;
  logic       frame_done;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] grant;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] f0[$];
  logic [7:0] f1[$];

  int vectors         = 0;
  int miscompares     = 0;
  int dv_seen         = 0;
  int rden0_seen      = 0;
  int rden1_seen      = 0;
  int frames_seen     = 0;
  int frames_expected = 0;
  int frame_bytes     = 0;
  int busy            = 0;
  bit outstanding     = 1'b0;

  always #5 out_clk = ~out_clk;

  uarttx_fifo_arbiter dut (
    .out_clk     (out_clk),
    .rst         (rst),
    .transmit_en (transmit_en),
    .fifo0_empty (fifo0_empty),
    .fifo1_empty (fifo1_empty),
    .fifo0_dout  (fifo0_dout),
    .fifo1_dout  (fifo1_dout),
    .fifo0_rden  (fifo0_rden),
    .fifo1_rden  (fifo1_rden),
    .tx_byte     (tx_byte),
    .tx_dv       (tx_dv),
    .tx_done     (tx_done),
    .grant       (grant),
    .frame_done  (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO models: data one cycle after rden, empty flag registered.
  always @(posedge out_clk) begin
    if (fifo0_rden && f0.size() > 0) fifo0_dout <= f0.pop_front();
    if (fifo1_rden && f1.size() > 0) fifo1_dout <= f1.pop_front();
    fifo0_empty <= (f0.size() == 0);
    fifo1_empty <= (f1.size() == 0);
  end

  // UART model plus scoreboard monitor, sampled on the falling edge.
  always @(negedge out_clk) begin
    exp_t e;
    tx_done = 1'b0;
    if (rst) begin
      busy        = 0;
      outstanding = 1'b0;
      frame_bytes = 0;
    end else begin
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          tx_done     = 1'b1;
          outstanding = 1'b0;
        end
      end
      if (fifo0_rden) begin
        rden0_seen++;
        check("rden0_nonempty", 32'(f0.size() != 0), 1);
        check("rden0_granted", grant, 2'b01);
      end
      if (fifo1_rden) begin
        rden1_seen++;
        check("rden1_nonempty", 32'(f1.size() != 0), 1);
        check("rden1_granted", grant, 2'b10);
      end
      if (tx_dv) begin
        dv_seen++;
        frame_bytes++;
        check("tx_dv_before_done", outstanding, 0);
        if (exp_q.size() == 0) begin
          check("tx_dv_unexpected", tx_byte, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", tx_byte, e.data);
          check("tx_grant", grant, e.grant);
        end
        outstanding = 1'b1;
        busy        = UART_LAT;
      end
      if (frame_done) begin
        frames_seen++;
        check("frame_done_grant", grant, 2'b00);
        check("frame_done_expected", 32'(frames_seen <= frames_expected), 1);
        check("frame_done_length", frame_bytes, FB + HDR_N);
        frame_bytes = 0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge out_clk);
      #1;
    end
  endtask

  task automatic fill(input int src, input int n, input int base, input int step);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(base + i * step);
      if (src == 0) f0.push_back(b);
      else          f1.push_back(b);
    end
  endtask

  task automatic expect_bytes(input int src, input int n, input int base, input int step);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data  = 8'(base + i * step);
      e.grant = (src == 0) ? 2'b01 : 2'b10;
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_hdr(input int src);
`ifdef UARTTX_ARB_HDR_EN
    exp_t e;
    e.data  = 8'hA0 | 8'(src);
    e.grant = (src == 0) ? 2'b01 : 2'b10;
    exp_q.push_back(e);
`else
    if (src > 1) $display("bad source index %0d", src);
`endif
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      tick();
      n++;
    end
    check(name, frames_seen, target);
  endtask

  task automatic wait_dv(input int target, input int budget, input string name);
    int n = 0;
    while (dv_seen < target && n < budget) begin
      tick();
      n++;
    end
    check(name, dv_seen, target);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_dv"}, tx_dv, 0);
    check({tag, "_tx_byte"}, tx_byte, 8'h00);
    check({tag, "_grant"}, grant, 2'b00);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_rden"}, {fifo1_rden, fifo0_rden}, 2'b00);
  endtask

  initial begin
    int d0, r0, r1;
    tick(2);
    check_outputs_zero("reset");
    rst         = 1'b0;
    transmit_en = 1'b1;

    // FIFO0 only: one full frame in order, then idle.
    frames_expected = 1;
    fill(0, FB, 8'h00, 1);
    expect_hdr(0);
    expect_bytes(0, FB, 8'h00, 1);
    wait_frames(1, FRAME_BUDGET, "single_frame_done");
    tick(10);
    check("single_idle_grant", grant, 2'b00);
    check("single_exp_drained", exp_q.size(), 0);

    // Fresh reset so the pointer favours source 0, then both sources contend.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    frames_expected = 3;
    fill(0, FB, 8'h10, 1);
    fill(1, FB, 8'h80, 3);
    expect_hdr(0);
    expect_bytes(0, FB, 8'h10, 1);
    expect_hdr(1);
    expect_bytes(1, FB, 8'h80, 3);
    wait_frames(3, 2 * FRAME_BUDGET, "both_frames_done");
    check("both_exp_drained", exp_q.size(), 0);

    // FIFO0 runs dry after byte 100; FIFO1 fills during the gap but must wait.
    frames_expected = 5;
    fill(0, 101, 8'h20, 1);
    expect_hdr(0);
    expect_bytes(0, 101, 8'h20, 1);
    wait_dv(dv_seen + 101 + HDR_N, FRAME_BUDGET, "gap_first_101");
    tick(6);
    fill(1, FB, 8'h40, 5);
    d0 = dv_seen;
    r0 = rden0_seen;
    r1 = rden1_seen;
    tick(50);
    check("gap_grant_held", grant, 2'b01);
    check("gap_no_tx_dv", dv_seen, d0);
    check("gap_no_rden0", rden0_seen, r0);
    check("gap_no_rden1", rden1_seen, r1);
    fill(0, FB - 101, 8'h20 + 101, 1);
    expect_bytes(0, FB - 101, 8'h20 + 101, 1);
    expect_hdr(1);
    expect_bytes(1, FB, 8'h40, 5);
    wait_frames(5, 2 * FRAME_BUDGET, "gap_frames_done");
    check("gap_exp_drained", exp_q.size(), 0);

    // Reset mid-frame at byte 400; the partial frame and its FIFO data are dropped.
    fill(0, FB, 8'h33, 7);
    expect_hdr(0);
    expect_bytes(0, FB, 8'h33, 7);
    wait_dv(dv_seen + 400 + HDR_N, FRAME_BUDGET, "rst_reach_400");
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    f0.delete();
    exp_q.delete();
    tick(3);
    rst = 1'b0;
    frames_expected = 6;
    fill(0, FB, 8'h99, 1);
    expect_hdr(0);
    expect_bytes(0, FB, 8'h99, 1);
    wait_frames(6, FRAME_BUDGET, "after_rst_frame_done");
    check("after_rst_exp_drained", exp_q.size(), 0);

    // transmit_en dropped at byte 10: the frame still completes, then no new grant.
    frames_expected = 7;
    fill(0, FB, 8'h05, 11);
    expect_hdr(0);
    expect_bytes(0, FB, 8'h05, 11);
    wait_dv(dv_seen + 10 + HDR_N, FRAME_BUDGET, "en_reach_10");
    transmit_en = 1'b0;
    wait_frames(7, FRAME_BUDGET, "en_frame_done");
    fill(1, 20, 8'hC0, 1);
    d0 = dv_seen;
    r1 = rden1_seen;
    tick(40);
    check("en_idle_grant", grant, 2'b00);
    check("en_idle_no_tx_dv", dv_seen, d0);
    check("en_idle_no_rden1", rden1_seen, r1);
    check("en_exp_drained", exp_q.size(), 0);
    check("total_frames", frames_seen, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
